// File: rtl/rd_empty_gen.sv
// Read-side empty/level generator for an async FIFO: synchronizes the write gray pointer and registers empty, almost_empty, level and sticky underflow.
// Write-pointer changes reach the flags P_SYNC_STAGES+1 cycles later; accepted reads reach them on the next edge. rd_inc blocks reads while empty.
module rd_empty_gen #(
  parameter int P_NUM_BITS    = 5,
  parameter int P_SYNC_STAGES = 2,
  parameter int P_AE_THRESH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P_NUM_BITS-1:0] wr_gry_ptr,
  input  logic                  rd_en,
  input  logic [P_NUM_BITS-1:0] rd_bin_next,
  output logic                  rd_inc,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [P_NUM_BITS-1:0] rd_level,
  output logic [P_NUM_BITS-1:0] wr_gry_sync,
  output logic                  underflow
);

  localparam logic [P_NUM_BITS-1:0] AE_THRESH = P_AE_THRESH[P_NUM_BITS-1:0];

  logic [P_NUM_BITS-1:0] sync_q [P_SYNC_STAGES];
  logic [P_NUM_BITS-1:0] wr_bin;
  logic [P_NUM_BITS-1:0] rd_gry_next;
  logic [P_NUM_BITS-1:0] level_d, level_q;
  logic                  empty_d, empty_q;
  logic                  ae_d, ae_q;
  logic                  underflow_d, underflow_q;

  // Binary bit i is the XOR of gray bits i..MSB, same result as the MSB-down chain.
  always_comb begin
    wr_bin = '0;
    for (int i = 0; i < P_NUM_BITS; i++) begin
      wr_bin[i] = ^(sync_q[P_SYNC_STAGES-1] >> i);
    end
  end

  always_comb begin
    rd_gry_next = rd_bin_next ^ (rd_bin_next >> 1);
    empty_d     = (rd_gry_next == sync_q[P_SYNC_STAGES-1]);
    level_d     = wr_bin - rd_bin_next;
    ae_d        = (level_d <= AE_THRESH);
    underflow_d = underflow_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      empty_q     <= 1'b1;
      ae_q        <= 1'b1;
      level_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync_q[0] <= wr_gry_ptr;
      for (int i = 1; i < P_SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      empty_q     <= empty_d;
      ae_q        <= ae_d;
      level_q     <= level_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_inc       = rd_en & ~empty_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_level     = level_q;
  assign wr_gry_sync  = sync_q[P_SYNC_STAGES-1];
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_rd_empty_gen.sv
// Scoreboard bench for rd_empty_gen: a driver pushes expectations from a pointer-history model, a monitor pops and compares.
module tb_rd_empty_gen;

  localparam int N = 5;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] wr_gry_ptr = '0;
  logic         rd_en = 1'b0;
  logic [N-1:0] rd_bin_next = '0;
  logic         rd_inc, empty, almost_empty, underflow;
  logic [N-1:0] rd_level, wr_gry_sync;

  rd_empty_gen #(.P_NUM_BITS(N), .P_SYNC_STAGES(S), .P_AE_THRESH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_gry_ptr   (wr_gry_ptr),
    .rd_en        (rd_en),
    .rd_bin_next  (rd_bin_next),
    .rd_inc       (rd_inc),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .wr_gry_sync  (wr_gry_sync),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk_inc;
    logic         inc;
    logic         emp;
    logic         ae;
    logic         uf;
    logic [N-1:0] lvl;
    logic [N-1:0] sync;
  } exp_t;

  exp_t         sbq[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  // Model state: what the DUT registers should hold right now.
  logic [N-1:0] wq[$];
  bit           known = 0;
  logic         m_empty = 1'b1, m_ae = 1'b1, m_uf = 1'b0;
  logic [N-1:0] m_lvl = '0;
  logic [N-1:0] wcnt = '0, rd_cnt = '0;

  function automatic logic [N-1:0] b2g(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    for (int v = 0; v < (1 << N); v++) begin
      b = v[N-1:0];
      if (b2g(b) == g) return b;
    end
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
    end
  endtask

  task automatic step(input bit r, input logic [N-1:0] wg, input bit re, input logic [N-1:0] rn);
    exp_t         e;
    logic [N-1:0] wb;
    @(negedge clk);
    rst = r; wr_gry_ptr = wg; rd_en = re; rd_bin_next = rn;
    e.chk_inc = known;
    e.inc     = re & ~m_empty;
    if (r) begin
      wq = {};
      repeat (S) wq.push_back('0);
      m_empty = 1'b1; m_ae = 1'b1; m_lvl = '0; m_uf = 1'b0;
      known = 1;
    end else begin
      wb      = g2b(wq[0]);
      m_uf    = m_uf | (re & m_empty);
      m_lvl   = wb - rn;
      m_empty = (wb == rn);
      m_ae    = (m_lvl <= 5'd2);
      wq.push_back(wg);
      void'(wq.pop_front());
    end
    e.emp = m_empty; e.ae = m_ae; e.uf = m_uf; e.lvl = m_lvl; e.sync = wq[0];
    sbq.push_back(e);
  endtask

  // Drives rd_bin_next the way a real read counter would, from the expected rd_inc.
  task automatic step_cnt(input bit r, input bit re);
    logic         inc;
    logic [N-1:0] rn;
    inc = re & ~m_empty;
    if (r) begin
      wcnt = '0; rd_cnt = '0;
    end
    rn = r ? '0 : rd_cnt + {{(N-1){1'b0}}, inc};
    step(r, b2g(wcnt), re, rn);
    rd_cnt = rn;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq[0];
        if (e.chk_inc) chk("rd_inc", 32'(rd_inc), 32'(e.inc));
        @(posedge clk);
        #1;
        chk("empty", 32'(empty), 32'(e.emp));
        chk("almost_empty", 32'(almost_empty), 32'(e.ae));
        chk("rd_level", 32'(rd_level), 32'(e.lvl));
        chk("wr_gry_sync", 32'(wr_gry_sync), 32'(e.sync));
        chk("underflow", 32'(underflow), 32'(e.uf));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    repeat (S) wq.push_back('0);
    step(1, 5'b10110, 0, 5'd9);
    step(1, 5'b01101, 1, 5'd3);
    // First write lands: empty falls three edges later, level 1 keeps almost_empty.
    repeat (3) step(0, 5'b00000, 0, 5'd0);
    repeat (5) step(0, 5'b00001, 0, 5'd0);
    // Full FIFO, then a wrapped read pointer.
    repeat (5) step(0, 5'b11000, 0, 5'd0);
    repeat (5) step(0, 5'b00010, 0, 5'b11110);
    // Reset in the middle of traffic with prior state nonzero.
    step(1, 5'b00010, 1, 5'd3);
    // Drain from 7 to empty, then keep reading into underflow and idle.
    wcnt = 5'd7; rd_cnt = '0;
    repeat (4) step_cnt(0, 0);
    repeat (10) step_cnt(0, 1);
    repeat (10) step_cnt(0, 0);
    step_cnt(1, 0);
    repeat (2) step_cnt(0, 0);
    // Random traffic with bounded level and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      bit r;
      bit re;
      r  = ($urandom_range(0, 299) == 0);
      re = $urandom_range(0, 1) != 0;
      if (!r && $urandom_range(0, 2) != 0 && 5'(wcnt - rd_cnt) < 5'd16) wcnt = wcnt + 5'd1;
      step_cnt(r, re);
    end
    repeat (4) @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
